mio_arb: RTL
============

Name: mio_arb

Overview:
- Two-master arbiter for the single shared data port of the memory/IO bus.
- Master 0 is the CPU data path. Master 1 is a secondary requester, such as a block-copy engine filling VRAM or RAM.
- Round-robin arbitration, one transfer per grant, an optional bounded lock for back-to-back transfers, and a per-transfer timeout that reports an error.
- Sits between the requesters and the bus decoder; the slave side drives the decoder's address, data and strobe inputs.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, maximum ACCESS cycles waiting for s_ready before abort (must be ≥1)
- MAX_LOCK, 8, maximum consecutive locked transfers by one owner (must be ≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- clrn  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  transfer request (level)
- m0_we / m1_we  in  1  1=write, 0=read
- m0_lock / m1_lock  in  1  request to keep ownership after this transfer
- m0_addr / m1_addr  in  AW  address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  master owns the port
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  one-cycle timeout pulse, coincident with done
- m0_rdata / m1_rdata  out  DW  read data, valid from the done cycle
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_we  out  1  slave write strobe
- s_re  out  1  slave read strobe
- s_rdata  in  DW  slave read data
- s_ready  in  1  slave completion
- owner  out  1  current or last owner index

Behaviour:
- Reset, asynchronous on clrn=0, immediate:
  - state IDLE; all gnt, done, err, s_we, s_re = 0; s_addr, s_wdata, rdata = 0.
  - last_owner = 1, so m0 wins the first tie; lock_cnt = 0; tmo_cnt = 0; owner = 0.
  - Reset mid-transfer drops the strobes at once. No done pulse is issued for the aborted transfer.
- States:
  - IDLE: no strobes.
  - ACCESS: exactly one of s_we or s_re high.
- IDLE arbitration, each cycle:
  - If lock is held: only the holder may start. The other master waits even if requesting. Lock is released if the holder's req=0 in this cycle.
  - Otherwise, with one requester, that master wins. With both requesting, the master != last_owner wins.
  - On a win, register addr, wdata and we from the winner into s_addr, s_wdata, s_we/s_re. Set owner and last_owner, clear tmo_cnt, go to ACCESS. The winner's gnt rises on the next cycle.
- ACCESS:
  - Strobes and gnt held stable. tmo_cnt increments each cycle.
  - s_ready=1 sampled: next cycle done=1 for the owner, and state goes to IDLE.
    - On a read, owner rdata <= s_rdata; on a write, rdata is unchanged.
    - Strobes drop in the done cycle.
  - tmo_cnt reaches TIMEOUT with s_ready still 0: next cycle done=1 and err=1. Strobes drop, rdata is unchanged, lock is released, state goes to IDLE.
- Latency: req in IDLE at cycle 0 → strobe at cycle 1 → s_ready at cycle 1 → done at cycle 2. Minimum throughput is one transfer per 2 cycles.
- gnt: high in ACCESS and in the done cycle. It also stays high through IDLE while the lock is held.
- req is level-sensitive:
  - A master must keep req and all request fields stable from assertion until its done.
  - req still high in the done cycle counts as a new request in that cycle's IDLE arbitration.
- Lock:
  - At successful completion, if the owner's lock=1, lock_cnt increments and ownership is held.
  - When lock_cnt reaches MAX_LOCK, the lock is forcibly released and lock_cnt cleared. Normal round-robin follows, so the other master wins if it is requesting.
  - lock_cnt is also cleared on any release.
- s_ready in IDLE is ignored.
- done and err are never asserted to both masters in the same cycle.

Test Plan:
- Single read: m0 read addr 0x10, s_ready in the first ACCESS cycle with s_rdata=0xDEADBEEF → s_re high for 1 cycle, m0_done at cycle 2, m0_rdata=0xDEADBEEF, m1 outputs all 0.
- Simultaneous requests after reset: both req held for 4 transfers, s_ready immediate → grant order m0, m1, m0, m1; no done overlap.
- Lock: m1 locked with continuous req and m0 also requesting, MAX_LOCK=8 → 8 consecutive m1 transfers, then m0 wins the next arbitration.
- Timeout: m0 write 0x5A5A5A5A to 0x20, s_ready held 0 → s_we high for exactly 15 cycles, then m0_done=1 and m0_err=1 together, strobes 0.
- Reset mid-transfer: clrn pulsed low during ACCESS → s_re/s_we and gnt 0 immediately, no done; after release m0 wins a tie.
- Write data retention: m1 read returns 0x1234, then m1 write completes → m1_rdata stays 0x1234.

Source files
------------

// File: rtl/mio_arb.sv
// mio_arb: two-master round-robin arbiter for the shared memory/IO data port.
// One transfer per grant, bounded ownership lock, and a per-transfer ready timeout.
module mio_arb #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 15,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_we,
  output logic          s_re,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready,
  output logic          owner,
  output logic          dbg_state
);

  // Handshake: a master holds req and its fields stable until its one-cycle
  // done; the slave completes a strobed access by raising s_ready for a cycle.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t        state;
  logic          last_owner;
  logic          lock_held;
  logic [LW-1:0] lock_cnt;
  logic [TW-1:0] tmo_cnt;

  logic          win;
  logic          win_id;
  logic          sel_we;
  logic          own_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign dbg_state = (state == ACCESS);

  // While locked only the holder may start; otherwise the non-last owner wins ties.
  always_comb begin
    win    = 1'b0;
    win_id = 1'b0;
    if (lock_held) begin
      win    = owner ? m1_req : m0_req;
      win_id = owner;
    end else if (m0_req && m1_req) begin
      win    = 1'b1;
      win_id = ~last_owner;
    end else if (m0_req) begin
      win    = 1'b1;
      win_id = 1'b0;
    end else if (m1_req) begin
      win    = 1'b1;
      win_id = 1'b1;
    end
  end

  assign sel_we    = win_id ? m1_we    : m0_we;
  assign sel_addr  = win_id ? m1_addr  : m0_addr;
  assign sel_wdata = win_id ? m1_wdata : m0_wdata;
  assign own_lock  = owner  ? m1_lock  : m0_lock;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      lock_held  <= 1'b0;
      lock_cnt   <= '0;
      tmo_cnt    <= '0;
      owner      <= 1'b0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_we       <= 1'b0;
      s_re       <= 1'b0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win) begin
            state      <= ACCESS;
            s_addr     <= sel_addr;
            s_wdata    <= sel_wdata;
            s_we       <= sel_we;
            s_re       <= ~sel_we;
            owner      <= win_id;
            last_owner <= win_id;
            tmo_cnt    <= '0;
            m0_gnt     <= ~win_id;
            m1_gnt     <= win_id;
          end else begin
            // Reaching here with a lock means the holder dropped req.
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            lock_held <= 1'b0;
            lock_cnt  <= '0;
          end
        end
        ACCESS: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (s_ready || tmo_cnt == TW'(TIMEOUT - 1)) begin
            state   <= IDLE;
            s_we    <= 1'b0;
            s_re    <= 1'b0;
            m0_done <= ~owner;
            m1_done <= owner;
            if (s_ready) begin
              if (s_re && !owner) m0_rdata <= s_rdata;
              if (s_re && owner)  m1_rdata <= s_rdata;
              if (own_lock && lock_cnt != LW'(MAX_LOCK - 1)) begin
                lock_held <= 1'b1;
                lock_cnt  <= lock_cnt + 1'b1;
              end else begin
                lock_held <= 1'b0;
                lock_cnt  <= '0;
              end
            end else begin
              m0_err    <= ~owner;
              m1_err    <= owner;
              lock_held <= 1'b0;
              lock_cnt  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
